// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Shared definitions for the inst/data SRAM arbiter.
//   - bus widths and the packed command layout {op, size, addr, wstrb, wdata}
//   - requester identity (owner) used by grant logic and the owner FIFO
//   - lock state encoding for the address-phase lock
package ysyx_22050710_sram_arbiter_pkg;

  localparam int SRAM_ADDR_WD    = 32;
  localparam int SRAM_WMASK_WD   = 8;
  localparam int SRAM_DATA_WD    = 64;
  localparam int ARB_OUTSTANDING = 2;

  localparam int CMD_WD = 1 + 2 + SRAM_ADDR_WD + SRAM_WMASK_WD + SRAM_DATA_WD;

  // Field positions inside the packed command, LSB first.
  localparam int CMD_WDATA_LSB = 0;
  localparam int CMD_WSTRB_LSB = CMD_WDATA_LSB + SRAM_DATA_WD;
  localparam int CMD_ADDR_LSB  = CMD_WSTRB_LSB + SRAM_WMASK_WD;
  localparam int CMD_SIZE_LSB  = CMD_ADDR_LSB + SRAM_ADDR_WD;
  localparam int CMD_OP_BIT    = CMD_SIZE_LSB + 2;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_state_e;

endpackage

// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// SRAM-like request/response bus used on both sides of the arbiter.
//   req / cmd        : requester -> responder, address phase
//   addr_ok          : responder -> requester, address phase accepted
//   data_ok / rdata  : responder -> requester, in-order response beat
// master = side issuing requests, slave = side answering them.
interface ysyx_22050710_sram_arbiter_if
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int BUS_CMD_WD  = CMD_WD,
  parameter int BUS_DATA_WD = SRAM_DATA_WD
);

  logic                   req;
  logic [BUS_CMD_WD-1:0]  cmd;
  logic                   addr_ok;
  logic                   data_ok;
  logic [BUS_DATA_WD-1:0] rdata;

  modport master (
    output req,
    output cmd,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  cmd,
    output addr_ok,
    output data_ok,
    output rdata
  );

endinterface

// File: rtl/ysyx_22050710_owner_fifo.sv
// In-order record of who owns each accepted-but-unanswered request.
// Ports:
//   i_clk, i_rst   clock, synchronous active-low reset
//   push, push_own enqueue the owner of an accepted address phase
//   pop            dequeue on a response beat
//   full, empty    occupancy flags
//   head           owner of the oldest outstanding request
// DEPTH must be a power of two so the pointers wrap without extra logic.
module ysyx_22050710_owner_fifo
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_OUTSTANDING
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   push,
  input  owner_e push_own,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam logic [PTR_WD:0] CNT_FULL = DEPTH[PTR_WD:0];

  logic [DEPTH-1:0]  mem;
  logic [PTR_WD-1:0] wr_ptr;
  logic [PTR_WD-1:0] rd_ptr;
  logic [PTR_WD:0]   count;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_own;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = owner_e'(mem[rd_ptr]);

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Shares one downstream SRAM port between the fetch (inst) and load/store
// (data) requesters. Data has fixed priority; a granted request stays
// locked onto the downstream port until it is accepted, and an owner FIFO
// steers each in-order response beat back to whoever issued it.
// Ports:
//   i_clk, i_rst   clock, synchronous active-low reset
//   inst           inst requester bus (slave side)
//   data           data requester bus (slave side)
//   sram           downstream bus (master side)
//   o_resp_err     pulse: response beat arrived with nothing outstanding
//
// Lock FSM
//   state   | meaning
//   LK_IDLE | no handshake in flight, grant follows priority
//   LK_INST | inst request presented but not yet accepted, held on port
//   LK_DATA | data request presented but not yet accepted, held on port
module ysyx_22050710_sram_arbiter
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = ARB_OUTSTANDING
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  ysyx_22050710_sram_arbiter_if.slave   inst,
  ysyx_22050710_sram_arbiter_if.slave   data,
  ysyx_22050710_sram_arbiter_if.master  sram,
  output logic                          o_resp_err
);

  lock_state_e lock_q;
  lock_state_e lock_d;

  logic   gnt_vld;
  owner_e gnt_own;
  logic   gnt_req;
  logic   accept;
  logic   pop;
  logic   full;
  logic   empty;
  owner_e head;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      lock_q <= LK_IDLE;
    end else begin
      lock_q <= lock_d;
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_own = OWN_INST;
    lock_d  = lock_q;

    case (lock_q)
      LK_INST: begin
        gnt_vld = 1'b1;
        gnt_own = OWN_INST;
      end
      LK_DATA: begin
        gnt_vld = 1'b1;
        gnt_own = OWN_DATA;
      end
      default: begin
        if (data.req) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_DATA;
        end else if (inst.req) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_INST;
        end
      end
    endcase

    gnt_req = gnt_vld && ((gnt_own == OWN_DATA) ? data.req : inst.req);

    // Full blocks the grant even if a pop happens this cycle; the freed
    // slot only becomes visible next cycle.
    sram.req = gnt_req && !full;
    sram.cmd = '0;
    if (gnt_vld) begin
      sram.cmd = (gnt_own == OWN_DATA) ? data.cmd : inst.cmd;
    end

    accept       = sram.req && sram.addr_ok;
    inst.addr_ok = accept && (gnt_own == OWN_INST);
    data.addr_ok = accept && (gnt_own == OWN_DATA);

    if (sram.req) begin
      if (sram.addr_ok) begin
        lock_d = LK_IDLE;
      end else begin
        lock_d = (gnt_own == OWN_DATA) ? LK_DATA : LK_INST;
      end
    end else if (lock_q != LK_IDLE && !gnt_req) begin
      // Locked requester withdrew its request; release rather than hang.
      lock_d = LK_IDLE;
    end
  end

  assign pop          = sram.data_ok && !empty;
  assign inst.data_ok = pop && (head == OWN_INST);
  assign data.data_ok = pop && (head == OWN_DATA);
  assign inst.rdata   = sram.rdata;
  assign data.rdata   = sram.rdata;
  assign o_resp_err   = sram.data_ok && empty;

  ysyx_22050710_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (accept),
    .push_own(gnt_own),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// queue-based reference model of the arbitration rules.
module tb_ysyx_22050710_sram_arbiter;
  import ysyx_22050710_sram_arbiter_pkg::*;

  typedef logic [CMD_WD-1:0]       cmd_t;
  typedef logic [SRAM_DATA_WD-1:0] dat_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic o_resp_err;

  ysyx_22050710_sram_arbiter_if inst_bus ();
  ysyx_22050710_sram_arbiter_if data_bus ();
  ysyx_22050710_sram_arbiter_if sram_bus ();

  ysyx_22050710_sram_arbiter dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .inst      (inst_bus),
    .data      (data_bus),
    .sram      (sram_bus),
    .o_resp_err(o_resp_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // flags bit order: [5]sram_req [4]inst_addr_ok [3]data_addr_ok
  //                  [2]inst_data_ok [1]data_data_ok [0]resp_err
  function automatic logic [5:0] flags();
    return {sram_bus.req, inst_bus.addr_ok, data_bus.addr_ok,
            inst_bus.data_ok, data_bus.data_ok, o_resp_err};
  endfunction

  function automatic cmd_t rnd_cmd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[CMD_WD-1:0];
  endfunction

  function automatic dat_t rnd_dat();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    inst_bus.req     = 1'b0;
    inst_bus.cmd     = '0;
    data_bus.req     = 1'b0;
    data_bus.cmd     = '0;
    sram_bus.addr_ok = 1'b0;
    sram_bus.data_ok = 1'b0;
    sram_bus.rdata   = '0;
  endtask

  task automatic do_reset();
    idle();
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (flags() !== 6'b000000) $display("FAIL reset_flags got=%b exp=%b", flags(), 6'b000000);
    else n_pass++;
    n_chk++;
    if (sram_bus.cmd !== '0) $display("FAIL reset_cmd got=%h exp=0", sram_bus.cmd);
    else n_pass++;
  endtask

  task automatic test_inst_only();
    cmd_t ci;
    do_reset();
    ci = rnd_cmd();
    inst_bus.req = 1'b1; inst_bus.cmd = ci; sram_bus.addr_ok = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b110000) $display("FAIL inst_only_accept got=%b exp=%b", flags(), 6'b110000);
    else n_pass++;
    n_chk++;
    if (sram_bus.cmd !== ci) $display("FAIL inst_only_cmd got=%h exp=%h", sram_bus.cmd, ci);
    else n_pass++;
    tick();
    inst_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
    sram_bus.data_ok = 1'b1; sram_bus.rdata = 64'h1234;
    #1;
    n_chk++;
    if (flags() !== 6'b000100) $display("FAIL inst_only_resp got=%b exp=%b", flags(), 6'b000100);
    else n_pass++;
    n_chk++;
    if (inst_bus.rdata !== 64'h1234) $display("FAIL inst_only_rdata got=%h exp=%h", inst_bus.rdata, 64'h1234);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_priority();
    cmd_t ci, cd;
    dat_t r1, r2;
    do_reset();
    ci = rnd_cmd(); cd = rnd_cmd(); r1 = rnd_dat(); r2 = rnd_dat();
    inst_bus.req = 1'b1; inst_bus.cmd = ci;
    data_bus.req = 1'b1; data_bus.cmd = cd;
    sram_bus.addr_ok = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b101000) $display("FAIL prio_data_first got=%b exp=%b", flags(), 6'b101000);
    else n_pass++;
    n_chk++;
    if (sram_bus.cmd !== cd) $display("FAIL prio_data_cmd got=%h exp=%h", sram_bus.cmd, cd);
    else n_pass++;
    tick();
    data_bus.req = 1'b0;
    #1;
    n_chk++;
    if (flags() !== 6'b110000) $display("FAIL prio_inst_next got=%b exp=%b", flags(), 6'b110000);
    else n_pass++;
    n_chk++;
    if (sram_bus.cmd !== ci) $display("FAIL prio_inst_cmd got=%h exp=%h", sram_bus.cmd, ci);
    else n_pass++;
    tick();
    idle();
    sram_bus.data_ok = 1'b1; sram_bus.rdata = r1;
    #1;
    n_chk++;
    if (flags() !== 6'b000010 || data_bus.rdata !== r1)
      $display("FAIL prio_resp_data got=%b/%h exp=%b/%h", flags(), data_bus.rdata, 6'b000010, r1);
    else n_pass++;
    tick();
    sram_bus.rdata = r2;
    #1;
    n_chk++;
    if (flags() !== 6'b000100 || inst_bus.rdata !== r2)
      $display("FAIL prio_resp_inst got=%b/%h exp=%b/%h", flags(), inst_bus.rdata, 6'b000100, r2);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_lock();
    cmd_t ci, cd;
    do_reset();
    ci = rnd_cmd(); cd = rnd_cmd();
    inst_bus.req = 1'b1; inst_bus.cmd = ci; sram_bus.addr_ok = 1'b0;
    #1;
    n_chk++;
    if (flags() !== 6'b100000 || sram_bus.cmd !== ci)
      $display("FAIL lock_t0 got=%b/%h exp=%b/%h", flags(), sram_bus.cmd, 6'b100000, ci);
    else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      tick();
      data_bus.req = 1'b1; data_bus.cmd = cd;
      #1;
      n_chk++;
      if (flags() !== 6'b100000 || sram_bus.cmd !== ci)
        $display("FAIL lock_hold_t%0d got=%b/%h exp=%b/%h", k, flags(), sram_bus.cmd, 6'b100000, ci);
      else n_pass++;
    end
    tick();
    sram_bus.addr_ok = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b110000 || sram_bus.cmd !== ci)
      $display("FAIL lock_release got=%b/%h exp=%b/%h", flags(), sram_bus.cmd, 6'b110000, ci);
    else n_pass++;
    tick();
    inst_bus.req = 1'b0;
    #1;
    n_chk++;
    if (flags() !== 6'b101000 || sram_bus.cmd !== cd)
      $display("FAIL lock_then_data got=%b/%h exp=%b/%h", flags(), sram_bus.cmd, 6'b101000, cd);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_full_order();
    cmd_t ci, cd;
    dat_t r1, r2;
    do_reset();
    ci = rnd_cmd(); cd = rnd_cmd(); r1 = rnd_dat(); r2 = rnd_dat();
    data_bus.req = 1'b1; data_bus.cmd = cd; inst_bus.cmd = ci; sram_bus.addr_ok = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b101000) $display("FAIL full_acc_data got=%b exp=%b", flags(), 6'b101000);
    else n_pass++;
    tick();
    data_bus.req = 1'b0; inst_bus.req = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b110000) $display("FAIL full_acc_inst got=%b exp=%b", flags(), 6'b110000);
    else n_pass++;
    tick();
    data_bus.req = 1'b1;
    sram_bus.data_ok = 1'b1; sram_bus.rdata = r1;
    #1;
    n_chk++;
    if (flags() !== 6'b000010 || data_bus.rdata !== r1)
      $display("FAIL full_block_pop got=%b/%h exp=%b/%h", flags(), data_bus.rdata, 6'b000010, r1);
    else n_pass++;
    n_chk++;
    if (sram_bus.cmd !== cd) $display("FAIL full_cmd got=%h exp=%h", sram_bus.cmd, cd);
    else n_pass++;
    tick();
    data_bus.req = 1'b0; inst_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
    sram_bus.rdata = r2;
    #1;
    n_chk++;
    if (flags() !== 6'b000100 || inst_bus.rdata !== r2)
      $display("FAIL full_resp_inst got=%b/%h exp=%b/%h", flags(), inst_bus.rdata, 6'b000100, r2);
    else n_pass++;
    tick();
    #1;
    n_chk++;
    if (flags() !== 6'b000001) $display("FAIL full_drained_err got=%b exp=%b", flags(), 6'b000001);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_resp_err();
    do_reset();
    sram_bus.data_ok = 1'b1; sram_bus.rdata = rnd_dat();
    #1;
    n_chk++;
    if (flags() !== 6'b000001) $display("FAIL resp_err_pulse got=%b exp=%b", flags(), 6'b000001);
    else n_pass++;
    tick();
    sram_bus.data_ok = 1'b0;
    #1;
    n_chk++;
    if (flags() !== 6'b000000) $display("FAIL resp_err_clear got=%b exp=%b", flags(), 6'b000000);
    else n_pass++;
    idle();
  endtask

  task automatic test_reset_mid();
    cmd_t ci, cd;
    do_reset();
    ci = rnd_cmd(); cd = rnd_cmd();
    data_bus.req = 1'b1; data_bus.cmd = cd; sram_bus.addr_ok = 1'b1;
    tick();
    data_bus.req = 1'b0; inst_bus.req = 1'b1; inst_bus.cmd = ci; sram_bus.addr_ok = 1'b0;
    #1;
    n_chk++;
    if (flags() !== 6'b100000) $display("FAIL rstmid_lock got=%b exp=%b", flags(), 6'b100000);
    else n_pass++;
    tick();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    idle();
    #1;
    n_chk++;
    if (flags() !== 6'b000000 || sram_bus.cmd !== '0)
      $display("FAIL rstmid_outputs got=%b/%h exp=%b/0", flags(), sram_bus.cmd, 6'b000000);
    else n_pass++;
    sram_bus.data_ok = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b000001) $display("FAIL rstmid_dropped got=%b exp=%b", flags(), 6'b000001);
    else n_pass++;
    tick();
    sram_bus.data_ok = 1'b0;
    inst_bus.req = 1'b1; inst_bus.cmd = ci;
    data_bus.req = 1'b1; data_bus.cmd = cd; sram_bus.addr_ok = 1'b1;
    #1;
    n_chk++;
    if (flags() !== 6'b101000 || sram_bus.cmd !== cd)
      $display("FAIL rstmid_lock_gone got=%b/%h exp=%b/%h", flags(), sram_bus.cmd, 6'b101000, cd);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_random();
    owner_e q[$];
    bit     m_lock;
    owner_e m_lock_own;
    bit     ir, dr, aok, dok;
    bit     has_own, oreq, e_sreq, acc;
    owner_e own;
    cmd_t   ci, cd, e_cmd;
    dat_t   rd;
    logic [5:0] e_flags;
    owner_e hd;

    do_reset();
    m_lock = 1'b0;
    m_lock_own = OWN_INST;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ir  = ($urandom % 4) != 0;
      dr  = ($urandom % 3) == 0;
      aok = ($urandom % 2) == 0;
      dok = ($urandom % 3) == 0;
      ci  = rnd_cmd();
      cd  = rnd_cmd();
      rd  = rnd_dat();
      inst_bus.req = ir; inst_bus.cmd = ci;
      data_bus.req = dr; data_bus.cmd = cd;
      sram_bus.addr_ok = aok; sram_bus.data_ok = dok; sram_bus.rdata = rd;
      #1;

      has_own = 1'b1;
      if (m_lock) own = m_lock_own;
      else if (dr) own = OWN_DATA;
      else if (ir) own = OWN_INST;
      else begin has_own = 1'b0; own = OWN_INST; end
      oreq   = has_own && ((own == OWN_DATA) ? dr : ir);
      e_sreq = oreq && (q.size() < ARB_OUTSTANDING);
      e_cmd  = has_own ? ((own == OWN_DATA) ? cd : ci) : '0;
      acc    = e_sreq && aok;
      hd     = (q.size() > 0) ? q[0] : OWN_INST;
      e_flags = {e_sreq, acc && own == OWN_INST, acc && own == OWN_DATA,
                 dok && q.size() > 0 && hd == OWN_INST,
                 dok && q.size() > 0 && hd == OWN_DATA,
                 dok && q.size() == 0};

      n_chk++;
      if (flags() !== e_flags) $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, flags(), e_flags);
      else n_pass++;
      n_chk++;
      if (sram_bus.cmd !== e_cmd) $display("FAIL rand_cmd cyc=%0d got=%h exp=%h", cyc, sram_bus.cmd, e_cmd);
      else n_pass++;
      if (dok && q.size() > 0) begin
        n_chk++;
        if (((hd == OWN_DATA) ? data_bus.rdata : inst_bus.rdata) !== rd)
          $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc,
                   (hd == OWN_DATA) ? data_bus.rdata : inst_bus.rdata, rd);
        else n_pass++;
      end

      if (dok && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(own);
      if (e_sreq) begin
        m_lock = !aok;
        m_lock_own = own;
      end else if (m_lock && !oreq) begin
        m_lock = 1'b0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_inst_only();
    test_priority();
    test_lock();
    test_full_order();
    test_resp_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
